// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, DATA_LENGTH data bits LSB first, optional even parity, stop).
// Latency: 2-cycle rx synchronizer, then rx_valid/frame_err/parity_err one cycle after the mid-stop sample.
// Backpressure: none. The result pulses last one cycle, and the consumer must capture them when they occur.
//
// Ports:
//    clk, rst             : rising-edge clock, synchronous active-high reset
//    rx                   : asynchronous serial input, idle high
//    rx_data              : last good data word, held between frames
//    rx_valid             : 1-cycle pulse when rx_data updates
//    frame_err            : 1-cycle pulse when the stop bit is sampled low
//    parity_err           : 1-cycle pulse on even-parity mismatch (tied 0 without parity)
//    busy                 : high whenever the receiver is not idle
// Build option: define UART_RX_PARITY_EN to add the even-parity bit between data and stop.
module uart_rx #(
   parameter int DATA_LENGTH  = 8,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   output logic [DATA_LENGTH-1:0] rx_data,
   output logic                   rx_valid,
   output logic                   frame_err,
   output logic                   parity_err,
   output logic                   busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_LENGTH + 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_LENGTH - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY  = 3'd3,
`endif
      S_STOP    = 3'd4,
      S_RECOVER = 3'd5
   } state_e;

   state_e                 state_q, state_d;
   logic                   rx_meta_q, rx_s_q;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic [DATA_LENGTH-1:0] shreg_q, shreg_d;
   logic [DATA_LENGTH-1:0] rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
   logic                   parity_err_q, parity_err_d;
   logic                   par_pend_q, par_pend_d;
`endif

   logic cnt_mid, cnt_last;
   assign cnt_mid  = (bit_cnt_q == CNT_MID);
   assign cnt_last = (bit_cnt_q == CNT_LAST);

   // State and datapath registers. Synchronizer flops reset to the idle line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shreg_q      <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
         par_pend_q   <= 1'b0;
`endif
      end else begin
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shreg_q      <= shreg_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
         par_pend_q   <= par_pend_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (!rx_s_q) state_d = S_START;
         // A line that is back high at mid start bit was a glitch.
         S_START:   if (cnt_mid) state_d = rx_s_q ? S_IDLE : S_DATA;
         S_DATA: begin
            if (cnt_last && (bit_idx_q == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY:  if (cnt_last) state_d = S_STOP;
`endif
         // Leaving at mid stop bit leaves half a bit to spot a back-to-back start edge.
         S_STOP:    if (cnt_last) state_d = rx_s_q ? S_IDLE : S_RECOVER;
         // A held-low break waits here so it reports only one frame error.
         S_RECOVER: if (rx_s_q) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Counters, shift register and registered result pulses.
   always_comb begin
      bit_cnt_d    = bit_cnt_q + CNT_W'(1);
      bit_idx_d    = bit_idx_q;
      shreg_d      = shreg_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
      par_pend_d   = par_pend_q;
`endif
      // The bit counter restarts on every state change and at every bit boundary.
      if ((state_d != state_q) || cnt_last || (state_q == S_IDLE) || (state_q == S_RECOVER))
         bit_cnt_d = '0;

      case (state_q)
         S_START: begin
            if (cnt_mid && !rx_s_q) begin
               bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
               par_pend_d = 1'b0;
`endif
            end
         end
         S_DATA: begin
            if (cnt_last) begin
               for (int i = 0; i < DATA_LENGTH; i++)
                  if (bit_idx_q == IDX_W'(i)) shreg_d[i] = rx_s_q;
               bit_idx_d = bit_idx_q + IDX_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         // Even parity: the parity bit equals the XOR of all data bits.
         S_PARITY:  if (cnt_last) par_pend_d = rx_s_q ^ (^shreg_q);
`endif
         S_STOP: begin
            if (cnt_last) begin
               if (!rx_s_q) begin
                  frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_pend_q) begin
                  parity_err_d = 1'b1;
`endif
               end else begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = shreg_q;
               end
            end
         end
         default: ;
      endcase
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_LENGTH, default 8, number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit period; legal range is 4 or more.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 Port rx_data, output, DATA_LENGTH bits: last correctly received data word.
REQ-007 Port rx_valid, output, 1 bit: one-cycle pulse when rx_data has been updated.
REQ-008 Port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-009 Port parity_err, output, 1 bit: one-cycle pulse when the parity check fails.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; this adds 2 cycles of latency.
REQ-012 Frame format SHALL be: 1 start bit (0), DATA_LENGTH data bits LSB first, optional parity bit (REQ-030), 1 stop bit (1).
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP, RECOVER, with a bit-period counter bit_cnt and a data index bit_idx.
REQ-014 IDLE: when rx_s==0, go to START and clear bit_cnt.
REQ-015 START: at bit_cnt==CLKS_PER_BIT/2-1 (mid start bit), check rx_s.
- rx_s==0: go to DATA and clear bit_cnt and bit_idx.
- rx_s==1 (glitch): go to IDLE with no output pulse.
REQ-016 DATA: at each bit_cnt==CLKS_PER_BIT-1, shift rx_s into shift register position bit_idx, clear bit_cnt and increment bit_idx.
- After bit DATA_LENGTH-1, go to PARITY if enabled, otherwise to STOP.
REQ-017 STOP: at bit_cnt==CLKS_PER_BIT-1, sample rx_s.
- rx_s==1 with no pending parity error: load rx_data from the shift register and pulse rx_valid for exactly 1 cycle on the next edge, then go to IDLE.
- rx_s==1 with a pending parity error: pulse parity_err for 1 cycle, leave rx_data unchanged, go to IDLE.
- rx_s==0: pulse frame_err for 1 cycle, leave rx_data unchanged, go to RECOVER.
REQ-018 RECOVER: stay until rx_s==1, then go to IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-019 rx_data SHALL hold its value between valid frames and SHALL never show partial data.
REQ-020 rx_valid, frame_err and parity_err SHALL be mutually exclusive in every cycle.
REQ-021 Back-to-back frames: a start bit that begins right after the mid-stop sample SHALL be detected with no lost frame.
REQ-022 The counters SHALL be sized to $clog2(CLKS_PER_BIT) and $clog2(DATA_LENGTH+1) bits; bit_cnt SHALL wrap to 0 only by explicit clear.

Reset
REQ-023 When rst is sampled high, the state SHALL be IDLE and the following SHALL be 0: rx_data, rx_valid, frame_err, parity_err, busy, all counters and the shift register.
REQ-024 Both synchronizer flops SHALL reset to 1 (idle line).
REQ-025 Reset mid-frame SHALL abandon the frame with no output pulse; reception restarts at the next falling edge after rst is released.

Configuration
REQ-030 Macro UART_RX_PARITY_EN.
- Defined: the PARITY state is present. At bit_cnt==CLKS_PER_BIT-1 it samples the even-parity bit. A mismatch against the XOR of the data bits is recorded as pending. Then go to STOP.
- Undefined: the PARITY state and its logic are absent, and parity_err is tied to 0.

Verification (CLKS_PER_BIT=16, DATA_LENGTH=8)
REQ-040 Send frame 0xA5, idle high before and after -> rx_valid is high for exactly 1 cycle, rx_data==0xA5, frame_err and parity_err stay 0, busy returns low.
REQ-041 Pulse rx low for 4 cycles, then high -> state returns to IDLE, no rx_valid, rx_data unchanged.
REQ-042 Send 0x3C, then a frame 0x77 with the stop bit driven low -> one frame_err pulse, rx_data stays 0x3C; holding rx low for 100 cycles gives no second frame_err.
REQ-043 Send frames 0x00 and 0xFF back-to-back with no idle gap -> two rx_valid pulses, with rx_data 0x00 then 0xFF.
REQ-044 Assert rst during data bit 3 of frame 0x5A, then send 0xC3 -> no output pulse from the aborted frame, then rx_valid with rx_data==0xC3.
REQ-045 With UART_RX_PARITY_EN defined, send 0x01 with parity bit 0 -> parity_err pulses once, no rx_valid; the same data with parity 1 -> rx_valid with 0x01.
